// File: rtl/cpu_types_pkg.sv
// Shared datapath types: instruction word, icache frame layout and icache FSM states.
// The frame struct is sized for the default 16-frame icache.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_FRAMES = 16;
    localparam int ICACHE_IDX_W  = $clog2(ICACHE_FRAMES);
    localparam int ICACHE_TAG_W  = 30 - ICACHE_IDX_W;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_stats.sv
// Wrapping 32-bit hit/miss event counters for the instruction cache.
// Only instantiated when ICACHE_STATS_EN is defined.
module icache_stats
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  hit_inc,
    input  logic  miss_inc,
    output word_t hit_count,
    output word_t miss_count
);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc)
                hit_count <= hit_count + 32'd1;
            if (miss_inc)
                miss_count <= miss_count + 32'd1;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-block instruction cache with zero-latency hits and a blocking fill.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache
    import cpu_types_pkg::*;
#(
    parameter int FRAMES = 16
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          imemREN,
    input  word_t         imemaddr,
    output logic          ihit,
    output word_t         imemload,
    output logic          iREN,
    output word_t         iaddr,
    input  logic          iwait,
    input  word_t         iload,
    output word_t         hit_count,
    output word_t         miss_count,
    output icache_state_t dbg_state
);

    localparam int IDX_W = $clog2(FRAMES);
    localparam int TAG_W = 30 - IDX_W;

    logic [FRAMES-1:0] valid;
    logic [TAG_W-1:0]  tags [FRAMES];
    word_t             data [FRAMES];

    icache_state_t state;
    word_t         miss_addr;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             hit;
    logic             miss;

    assign idx      = imemaddr[IDX_W+1:2];
    assign tag      = imemaddr[31:IDX_W+2];
    assign fill_idx = miss_addr[IDX_W+1:2];
    assign fill_tag = miss_addr[31:IDX_W+2];

    assign hit  = (state == IDLE) && imemREN && valid[idx] && (tags[idx] == tag);
    assign miss = (state == IDLE) && imemREN && !hit;

    // Fill handshake: iREN holds high for the whole FETCH state; the word on iload is
    // taken in the first cycle with iREN=1 and iwait=0, and iREN drops the next cycle.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_addr <= '0;
            valid     <= '0;
            for (int i = 0; i < FRAMES; i++) begin
                tags[i] <= '0;
                data[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        miss_addr <= {imemaddr[31:2], 2'b00};
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    // The fill completes even if the fetch request was redirected meanwhile.
                    if (!iwait) begin
                        valid[fill_idx] <= 1'b1;
                        tags[fill_idx]  <= fill_tag;
                        data[fill_idx]  <= iload;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ihit      = hit;
    assign imemload  = data[idx];
    assign iREN      = (state == FETCH);
    assign iaddr     = miss_addr;
    assign dbg_state = state;

`ifdef ICACHE_STATS_EN
    icache_stats u_stats (
        .CLK        (CLK),
        .nRST       (nRST),
        .hit_inc    (hit),
        .miss_inc   (miss),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetch traffic
// checked against an address-level model of a 16-frame direct-mapped cache.
module tb_icache;
    import cpu_types_pkg::*;

`ifdef ICACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          nRST;
    logic          imemREN;
    logic [31:0]   imemaddr;
    logic          ihit;
    logic [31:0]   imemload;
    logic          iREN;
    logic [31:0]   iaddr;
    logic          iwait;
    logic [31:0]   iload;
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;
    icache_state_t dbg_state;

    icache #(.FRAMES(16)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .dbg_state  (dbg_state)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Model: which word address each index holds, and that word's contents
    bit          m_valid [16];
    logic [29:0] m_line  [16];
    logic [31:0] m_data  [16];
    int          exp_hits;
    int          exp_misses;
    logic [31:0] exp_q [$];

    function automatic int fidx(input logic [31:0] a);
        return int'(a[5:2]);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[fidx(a)] && (m_line[fidx(a)] == a[31:2]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_line[i]  = '0;
            m_data[i]  = '0;
        end
        exp_hits   = 0;
        exp_misses = 0;
        exp_q.delete();
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = '0;
        iwait    = 1'b1;
        iload    = '0;
        tick();
        nRST = 1'b1;
        model_clear();
    endtask

    task automatic check_counters(input string name);
        logic [31:0] eh;
        logic [31:0] em;
        eh = STATS ? 32'(exp_hits) : 32'd0;
        em = STATS ? 32'(exp_misses) : 32'd0;
        checks++;
        if (hit_count !== eh) begin
            errors++;
            $display("FAIL %s hit_count: got %0d expected %0d", name, hit_count, eh);
        end
        checks++;
        if (miss_count !== em) begin
            errors++;
            $display("FAIL %s miss_count: got %0d expected %0d", name, miss_count, em);
        end
    endtask

    // One complete fetch of address a; on a miss the fill sees nwait busy cycles and returns d
    task automatic fetch(input logic [31:0] a, input int nwait, input logic [31:0] d);
        logic [31:0] expw;
        imemREN  = 1'b1;
        imemaddr = a;
        iwait    = 1'b1;
        iload    = $urandom;
        #2;
        if (model_hit(a)) begin
            checks++;
            if (ihit !== 1'b1 || imemload !== m_data[fidx(a)]) begin
                errors++;
                $display("FAIL hit %h: ihit=%b data=%h expected ihit=1 data=%h",
                         a, ihit, imemload, m_data[fidx(a)]);
            end
            checks++;
            if (iREN !== 1'b0) begin
                errors++;
                $display("FAIL hit_iren %h: got %b expected 0", a, iREN);
            end
            exp_hits++;
            tick();
        end else begin
            checks++;
            if (ihit !== 1'b0 || iREN !== 1'b0) begin
                errors++;
                $display("FAIL miss_detect %h: ihit=%b iREN=%b expected 0 0", a, ihit, iREN);
            end
            exp_misses++;
            exp_q.push_back(d);
            tick();
            for (int k = 0; k <= nwait; k++) begin
                iwait = (k < nwait);
                iload = (k < nwait) ? $urandom : d;
                #2;
                checks++;
                if (iREN !== 1'b1 || iaddr !== {a[31:2], 2'b00} || ihit !== 1'b0
                    || dbg_state !== FETCH) begin
                    errors++;
                    $display("FAIL fill %h cycle %0d: iREN=%b iaddr=%h ihit=%b expected 1 %h 0",
                             a, k, iREN, iaddr, ihit, {a[31:2], 2'b00});
                end
                tick();
            end
            m_valid[fidx(a)] = 1'b1;
            m_line[fidx(a)]  = a[31:2];
            m_data[fidx(a)]  = d;
            iwait = 1'b1;
            iload = $urandom;
            #2;
            expw = exp_q.pop_front();
            checks++;
            if (ihit !== 1'b1 || imemload !== expw || iREN !== 1'b0) begin
                errors++;
                $display("FAIL post_fill_hit %h: ihit=%b data=%h iREN=%b expected 1 %h 0",
                         a, ihit, imemload, iREN, expw);
            end
            exp_hits++;
            tick();
        end
    endtask

    task automatic idle_cycle(input logic [31:0] a);
        imemREN  = 1'b0;
        imemaddr = a;
        iwait    = 1'b1;
        #2;
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0 || imemload !== m_data[fidx(a)]) begin
            errors++;
            $display("FAIL idle %h: ihit=%b iREN=%b data=%h expected 0 0 %h",
                     a, ihit, iREN, imemload, m_data[fidx(a)]);
        end
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        tick();
        #2;
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'h0 || imemload !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ihit=%b iREN=%b iaddr=%h data=%h expected all 0",
                     ihit, iREN, iaddr, imemload);
        end
        check_counters("reset");
        tick();
    endtask

    task automatic test_cold_miss();
        apply_reset();
        fetch(32'h0000_0040, 3, 32'h2002_0001);
    endtask

    task automatic test_hit();
        fetch(32'h0000_0040, 0, 32'h0);
        #2;
        check_counters("hit");
    endtask

    task automatic test_conflict();
        fetch(32'h0000_0440, 1, 32'hCAFE_0440);
        fetch(32'h0000_0040, 2, 32'h2002_0001);
        fetch(32'h0000_0040, 0, 32'h0);
    endtask

    task automatic test_redirect();
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0080;
        #2;
        checks++;
        if (ihit !== 1'b0) begin
            errors++;
            $display("FAIL redirect_miss: ihit=%b expected 0", ihit);
        end
        exp_misses++;
        tick();
        imemREN  = 1'b0;
        imemaddr = 32'h0000_0100;
        for (int k = 0; k < 3; k++) begin
            iwait = (k < 2);
            iload = 32'h8080_0080;
            #2;
            checks++;
            if (iREN !== 1'b1 || iaddr !== 32'h0000_0080) begin
                errors++;
                $display("FAIL redirect_fill %0d: iREN=%b iaddr=%h expected 1 00000080",
                         k, iREN, iaddr);
            end
            tick();
        end
        m_valid[0] = 1'b1;
        m_line[0]  = 30'h20;
        m_data[0]  = 32'h8080_0080;
        iwait = 1'b1;
        idle_cycle(32'h0000_0100);
        fetch(32'h0000_0080, 0, 32'h0);
        fetch(32'h0000_0100, 1, 32'h0100_0100);
    endtask

    task automatic test_reset_mid_fetch();
        fetch(32'h0000_0040, 0, 32'h2002_0001);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0204;
        iwait    = 1'b1;
        tick();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        model_clear();
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0040;
        #2;
        checks++;
        if (iREN !== 1'b0 || ihit !== 1'b0 || imemload !== 32'h0 || iaddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_fetch: iREN=%b ihit=%b data=%h iaddr=%h expected all 0",
                     iREN, ihit, imemload, iaddr);
        end
        check_counters("reset_mid_fetch");
        imemREN = 1'b0;
        tick();
        fetch(32'h0000_0040, 1, 32'h2002_0001);
    endtask

    task automatic test_stats();
        apply_reset();
        fetch(32'h0000_0040, 1, 32'h1111_0040);
        fetch(32'h0000_0084, 0, 32'h2222_0084);
        fetch(32'h0000_0040, 0, 32'h0);
        #2;
        checks++;
        if (hit_count !== (STATS ? 32'd3 : 32'd0) || miss_count !== (STATS ? 32'd2 : 32'd0)) begin
            errors++;
            $display("FAIL stats: hit=%0d miss=%0d expected %0d %0d", hit_count, miss_count,
                     STATS ? 3 : 0, STATS ? 2 : 0);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        apply_reset();
        for (int n = 0; n < 120; n++) begin
            a = 32'($urandom_range(0, 3)) << 6;
            a = a | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                idle_cycle($urandom);
            fetch(a, $urandom_range(0, 3), $urandom);
        end
        #2;
        check_counters("random");
    endtask

    initial begin
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = '0;
        iwait    = 1'b1;
        iload    = '0;
        model_clear();
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_redirect();
        test_reset_mid_fetch();
        test_stats();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, single-word-block instruction cache between the pipelined CPU datapath's fetch port and the memory controller's instruction port. Serves `imemREN`/`imemaddr` with zero-latency hits (`ihit`, `imemload`). On a miss it latches the address, issues a blocking fill through `iREN`/`iaddr`/`iwait`/`iload`, writes the frame, and then serves the hit.

## Interface
- `FRAMES`, default 16: number of frames; power of two, ≥2. Index width `IDX_W = $clog2(FRAMES)`; tag width `TAG_W = 30 - IDX_W`.
- `CLK` in 1: clock, all state updates on rising edge.
- `nRST` in 1: reset, synchronous, active-low.
- `imemREN` in 1: fetch request from datapath.
- `imemaddr` in 32: fetch byte address; bits [1:0] ignored.
- `ihit` out 1: fetch data valid this cycle.
- `imemload` out 32: instruction word.
- `iREN` out 1: fill request to memory controller.
- `iaddr` out 32: fill word address, bits [1:0] = 0.
- `iwait` in 1: memory busy; fill data valid in the cycle `iREN`=1 and `iwait`=0.
- `iload` in 32: fill data.
- `hit_count` out 32: hit counter (see Configuration).
- `miss_count` out 32: miss counter (see Configuration).

## Operation
- Address split: tag = `imemaddr[31:IDX_W+2]`, index = `imemaddr[IDX_W+1:2]`.
- Frame = {valid, tag, data}. All frames invalid after reset.
- FSM states are IDLE and FETCH.
- IDLE:
  - Hit = `imemREN` & valid[idx] & tag match. On a hit, `ihit`=1 and `imemload`=data[idx], combinationally.
  - On a miss with `imemREN`=1: `ihit`=0, latch `{imemaddr[31:2],2'b00}` into `miss_addr`, next state is FETCH.
  - `imemREN`=0: `ihit`=0, no state change.
- FETCH:
  - Drive `iREN`=1 and `iaddr`=`miss_addr`; `ihit`=0.
  - Hold until `iwait`=0. In that cycle, write frame[miss_addr idx] = {1, miss_addr tag, `iload`} and go to IDLE.
- Fill is never abandoned.
  - If `imemREN` drops or `imemaddr` changes mid-FETCH (branch/jump redirect, halt), the fill for `miss_addr` still completes.
  - IDLE then re-evaluates the current request.
- A fill overwrites any valid frame at that index: direct-mapped, no replacement choice.
- `imemload` = data[idx of `imemaddr`] whenever not hitting; the value is don't-care for the consumer but deterministic (0 for never-filled frames).

## Timing
- Hit latency is 0 cycles: `ihit` is combinational from `imemaddr` in IDLE.
- Miss: detect cycle (IDLE), then ≥1 FETCH cycle, then the hit in the cycle after the fill completes.
  - Miss latency = N+2 cycles, where N = number of `iwait`=1 cycles.
- `iREN` is registered-state driven. It is never asserted in IDLE and never asserted in the cycle after fill completion.
- Reset (`nRST`=0 at an edge), including mid-FETCH:
  - state=IDLE, all valid=0, data=0, tag=0, `miss_addr`=0, counters=0.
  - Next cycle: `ihit`=0, `iREN`=0, `iaddr`=0, `imemload`=0.
- Simultaneous fill and lookup of the same index: the fill is visible from the next cycle only (no bypass).

## Configuration
- `ICACHE_STATS_EN` defined:
  - `hit_count` increments in each IDLE cycle with a hit.
  - `miss_count` increments on each IDLE→FETCH transition.
  - Both are 32-bit, wrap at 2^32−1 → 0, and clear on reset.
- Undefined: no counter logic; both outputs are tied to 0.

## Structure
- `cpu_types_pkg` holds:
  - `icache_frame_t` packed struct {valid, tag[TAG_W], data word_t}, with the tag width derived from the default `FRAMES`.
  - `icache_state_t` enum {IDLE, FETCH}.
- Counters live in sub-module `icache_stats` (ports: `CLK`, `nRST`, `hit_inc`, `miss_inc`, `hit_count`, `miss_count`), instantiated only under `ICACHE_STATS_EN`.

## Test plan
- Cold miss: reset, then fetch 0x0000_0040 with `iwait`=1 for 3 cycles and `iload`=0x2002_0001.
  - Expect `iREN`=1 with `iaddr`=0x40 for 4 cycles.
  - Expect `ihit`=1 and `imemload`=0x2002_0001 on the 6th cycle.
- Hit: re-fetch 0x40 → `ihit`=1 the same cycle, `iREN`=0; `hit_count` increments by 1 with stats on.
- Conflict: with FRAMES=16, fill 0x40 then fetch 0x440 (same index 0, different tag).
  - 0x440 misses and fills.
  - Re-fetch 0x40 misses again.
- Redirect mid-fill: miss on 0x80, then change `imemaddr` to 0x100 and drop `imemREN` during FETCH.
  - Fill of 0x80 completes.
  - 0x80 then hits with 0 latency.
- Reset mid-FETCH: `nRST`=0 during FETCH.
  - Next cycle: `iREN`=0, `ihit`=0, `imemload`=0.
  - Previously filled 0x40 now misses.
- Stats macro: 3 hits and 2 misses → `hit_count`=3, `miss_count`=2 when defined; both 0 when undefined.
